// File: rtl/bist_pkg.sv
// bist_pkg: shared March C- encodings (states, operations, elements and their op lists)
package bist_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   typedef enum logic [1:0] {W0, W1, R0, R1} op_t;
   typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_t;
   // one bit per element, element 0 in the lsb
   localparam logic [5:0] ELEM_DOWN = 6'b111000;
   localparam logic [5:0] ELEM_TWO_OPS = 6'b011110;
   localparam logic [11:0] OP_FIRST = {R0, R1, R0, R1, R0, W0};
   localparam logic [11:0] OP_SECOND = {W0, W0, W1, W0, W1, W0};
   function automatic logic is_down(elem_t e);
      return ELEM_DOWN[e];
   endfunction
   function automatic logic two_ops(elem_t e);
      return ELEM_TWO_OPS[e];
   endfunction
   function automatic op_t elem_op(elem_t e, logic slot);
      return op_t'(slot ? OP_SECOND[{e, 1'b0} +: 2] : OP_FIRST[{e, 1'b0} +: 2]);
   endfunction
endpackage

// File: rtl/bist_read_compare.sv
// bist_read_compare: read-latency delay line, background comparator and first-fail capture
module bist_read_compare #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 20,
   parameter int RD_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              flush_i,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic              exp_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [2:0]        elem_i,
   input  logic [DATA_W-1:0] rddata_i,
   output logic              fail_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [2:0]        fail_elem_o
);
   logic [RD_LAT-1:0] vld;
   logic [RD_LAT-1:0] exp_q;
   logic [RD_LAT-1:0][ADDR_W-1:0] addr_q;
   logic [RD_LAT-1:0][2:0] elem_q;
   logic mism;
   assign mism = vld[RD_LAT-1] && !flush_i && rddata_i != {DATA_W{exp_q[RD_LAT-1]}};
   always_ff @(posedge clk_i) begin
      exp_q[0] <= exp_i;
      addr_q[0] <= addr_i;
      elem_q[0] <= elem_i;
      for (int i = 1; i < RD_LAT; i++) begin
         exp_q[i] <= exp_q[i-1];
         addr_q[i] <= addr_q[i-1];
         elem_q[i] <= elem_q[i-1];
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         vld <= '0;
         fail_o <= 1'b0;
         fail_addr_o <= '0;
         fail_elem_o <= '0;
      end else begin
         vld[0] <= push_i && !flush_i;
         for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1] && !flush_i;
         if (clear_i) begin
            fail_o <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= '0;
         end else if (mism && !fail_o) begin
            fail_o <= 1'b1;
            fail_addr_o <= addr_q[RD_LAT-1];
            fail_elem_o <= elem_q[RD_LAT-1];
         end
      end
   end
endmodule

// File: rtl/bram_bist_march_ctrl.sv
// bram_bist_march_ctrl: March C- sequencer for one DPSRAM half-block, one operation per cycle
module bram_bist_march_ctrl
   import bist_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 20,
   parameter int RD_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              abort_i,
   output logic              bist_active_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              we_o,
   output logic              re_o,
   output logic [DATA_W-1:0] wrdata_o,
   output logic [DATA_W-1:0] bitmask_o,
   input  logic [DATA_W-1:0] rddata_i,
   output logic              done_o,
   output logic              fail_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [2:0]        fail_elem_o
);
   localparam logic [2:0] LAT = 3'(RD_LAT);
   localparam logic [ADDR_W-1:0] ONE = 1;
   state_t state;
   elem_t elem, n_elem;
   op_t op, n_op;
   logic slot, n_slot, last_op, end_addr, fin, flush, clear;
   logic [ADDR_W-1:0] n_addr;
   logic [2:0] cnt;
   always_comb begin
      last_op = !two_ops(elem) || slot;
      end_addr = is_down(elem) ? addr_o == '0 : addr_o == '1;
      fin = last_op && end_addr && elem == M5;
      n_elem = last_op && end_addr && !fin ? elem_t'(elem + 3'd1) : elem;
      n_slot = !last_op;
      n_addr = !last_op ? addr_o : end_addr ? {ADDR_W{is_down(n_elem)}} : is_down(elem) ? addr_o - ONE : addr_o + ONE;
      n_op = elem_op(n_elem, n_slot);
      flush = (state == RUN || state == DRAIN) && abort_i;
      clear = (state == IDLE || state == DONE) && start_i;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
         elem <= M0;
         slot <= 1'b0;
         op <= W0;
         cnt <= '0;
         bist_active_o <= 1'b0;
         addr_o <= '0;
         we_o <= 1'b0;
         re_o <= 1'b0;
         wrdata_o <= '0;
         bitmask_o <= '0;
         done_o <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (start_i) begin
               state <= RUN;
               elem <= M0;
               slot <= 1'b0;
               op <= W0;
               addr_o <= '0;
               we_o <= 1'b1;
               re_o <= 1'b0;
               wrdata_o <= '0;
               bist_active_o <= 1'b1;
               bitmask_o <= '1;
               done_o <= 1'b0;
            end
            RUN: if (abort_i || fin) begin
               state <= abort_i ? IDLE : DRAIN;
               we_o <= 1'b0;
               re_o <= 1'b0;
               cnt <= '0;
               bist_active_o <= !abort_i;
               bitmask_o <= {DATA_W{!abort_i}};
            end else begin
               elem <= n_elem;
               slot <= n_slot;
               op <= n_op;
               addr_o <= n_addr;
               we_o <= n_op == W0 || n_op == W1;
               re_o <= n_op == R0 || n_op == R1;
               wrdata_o <= {DATA_W{n_op == W1}};
            end
            DRAIN: if (abort_i || cnt == LAT) begin
               state <= abort_i ? IDLE : DONE;
               done_o <= !abort_i;
               bist_active_o <= 1'b0;
               bitmask_o <= '0;
            end else cnt <= cnt + 3'd1;
         endcase
      end
   end
   bist_read_compare #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_cmp (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .flush_i     (flush),
      .clear_i     (clear),
      .push_i      (re_o),
      .exp_i       (op == R1),
      .addr_i      (addr_o),
      .elem_i      (elem),
      .rddata_i    (rddata_i),
      .fail_o      (fail_o),
      .fail_addr_o (fail_addr_o),
      .fail_elem_o (fail_elem_o)
   );
endmodule

// File: tb/tb_bram_bist_march_ctrl.sv
// tb_bram_bist_march_ctrl: directed March C- bench with RAM models, fault injection and an op-trace scoreboard
module tb_bram_bist_march_ctrl;
   logic clk = 1'b0;
   logic rst_n, abort, start1, start3;
   logic bist1, we1, re1, done1, fail1, bist3, we3, re3, done3, fail3;
   logic [1:0] addr1, faddr1, addr3, faddr3;
   logic [19:0] wrdata1, bitmask1, rd1, wrdata3, bitmask3;
   logic [2:0] felem1, felem3;
   logic [19:0] mem1 [4];
   logic [19:0] mem3 [4];
   logic [19:0] p3 [3];
   logic f1_en = 1'b0, f1_val = 1'b0, f3_en = 1'b0, f3_val = 1'b0;
   logic [1:0] f1_addr = '0, f3_addr = '0;
   int f1_bit = 0, f3_bit = 0;
   int tests = 0, fails = 0;
   bit mon_en = 1'b0;
   logic [23:0] sb [$];
   always #5 clk = ~clk;
   bram_bist_march_ctrl #(.ADDR_W(2), .DATA_W(20), .RD_LAT(1)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .abort_i(abort), .bist_active_o(bist1),
      .addr_o(addr1), .we_o(we1), .re_o(re1), .wrdata_o(wrdata1), .bitmask_o(bitmask1),
      .rddata_i(rd1), .done_o(done1), .fail_o(fail1), .fail_addr_o(faddr1), .fail_elem_o(felem1));
   bram_bist_march_ctrl #(.ADDR_W(2), .DATA_W(20), .RD_LAT(3)) dut3 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start3), .abort_i(abort), .bist_active_o(bist3),
      .addr_o(addr3), .we_o(we3), .re_o(re3), .wrdata_o(wrdata3), .bitmask_o(bitmask3),
      .rddata_i(p3[2]), .done_o(done3), .fail_o(fail3), .fail_addr_o(faddr3), .fail_elem_o(felem3));
   function automatic logic [19:0] flt(input logic [19:0] d, input logic [1:0] a, input logic en,
                                       input logic [1:0] fa, input int b, input logic v);
      logic [19:0] r;
      r = d;
      if (en && a == fa) r[b] = v;
      return r;
   endfunction
   // ideal RAMs; stuck-at faults are applied on the read path
   always @(posedge clk) begin
      if (we1) mem1[addr1] <= wrdata1;
      rd1 <= flt(mem1[addr1], addr1, f1_en, f1_addr, f1_bit, f1_val);
      if (we3) mem3[addr3] <= wrdata3;
      p3[0] <= flt(mem3[addr3], addr3, f3_en, f3_addr, f3_bit, f3_val);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push_trace();
      int nops [6] = '{1, 2, 2, 2, 2, 1};
      bit down [6] = '{0, 0, 0, 1, 1, 1};
      int opa [6] = '{0, 2, 3, 2, 3, 2};
      int opb [6] = '{0, 1, 0, 1, 0, 0};
      for (int e = 0; e < 6; e++)
         for (int s = 0; s < 4; s++)
            for (int o = 0; o < nops[e]; o++) begin
               int c;
               logic [1:0] a;
               c = o == 0 ? opa[e] : opb[e];
               a = down[e] ? 2'(3 - s) : 2'(s);
               sb.push_back({c < 2, c >= 2, a, (c == 1) ? 20'hFFFFF : 20'h0});
            end
   endtask
   always @(negedge clk) begin
      if (mon_en && (we1 || re1)) begin
         chk("strobe_exclusive", 32'(we1 & re1), 32'd0);
         if (sb.size() == 0) chk("extra_op", {8'd0, we1, re1, addr1, 20'd0}, 32'd0);
         else chk("op_trace", {8'd0, we1, re1, addr1, we1 ? wrdata1 : 20'd0}, {8'd0, sb.pop_front()});
      end
   end
   task automatic run(input bit sel, input bit extra, output int edges, output int ops);
      edges = -1;
      if (sel) start3 = 1'b1; else start1 = 1'b1;
      tick();
      start1 = 1'b0;
      start3 = 1'b0;
      ops = sel ? int'(we3 | re3) : int'(we1 | re1);
      for (int k = 1; k <= 300 && edges < 0; k++) begin
         start1 = !sel && extra && (k == 11 || k == 41);
         tick();
         start1 = 1'b0;
         if (sel ? done3 : done1) edges = k;
         else ops += sel ? int'(we3 | re3) : int'(we1 | re1);
      end
   endtask
   task automatic chk_zero1(input string tag);
      chk({tag, "_bist"}, 32'(bist1), 0);
      chk({tag, "_addr"}, 32'(addr1), 0);
      chk({tag, "_we"}, 32'(we1), 0);
      chk({tag, "_re"}, 32'(re1), 0);
      chk({tag, "_wrdata"}, 32'(wrdata1), 0);
      chk({tag, "_bitmask"}, 32'(bitmask1), 0);
      chk({tag, "_done"}, 32'(done1), 0);
      chk({tag, "_fail"}, 32'(fail1), 0);
      chk({tag, "_faddr"}, 32'(faddr1), 0);
      chk({tag, "_felem"}, 32'(felem1), 0);
   endtask
   initial begin
      int edges, ops;
      rst_n = 1'b0;
      abort = 1'b0;
      start1 = 1'b0;
      start3 = 1'b0;
      repeat (3) tick();
      chk_zero1("reset");
      chk("reset_done3", 32'(done3), 0);
      chk("reset_bist3", 32'(bist3), 0);
      rst_n = 1'b1;
      tick();
      // clean run with full op trace
      push_trace();
      mon_en = 1'b1;
      run(1'b0, 1'b0, edges, ops);
      mon_en = 1'b0;
      chk("clean_done_edges", 32'(edges), 42);
      chk("clean_run_ops", 32'(ops), 40);
      chk("clean_trace_left", 32'(sb.size()), 0);
      chk("clean_fail", 32'(fail1), 0);
      chk("clean_bist_in_done", 32'(bist1), 0);
      // stuck-at-0 bit 7 at addr 2
      f1_en = 1'b1; f1_addr = 2'd2; f1_bit = 7; f1_val = 1'b0;
      run(1'b0, 1'b0, edges, ops);
      chk("sa0_done_edges", 32'(edges), 42);
      chk("sa0_fail", 32'(fail1), 1);
      chk("sa0_faddr", 32'(faddr1), 2);
      chk("sa0_felem", 32'(felem1), 2);
      repeat (3) tick();
      chk("sa0_hold_faddr", 32'(faddr1), 2);
      chk("sa0_hold_felem", 32'(felem1), 2);
      // abort at RUN cycle 15 while a faulty read is still in the compare pipe
      f1_en = 1'b1; f1_addr = 2'd1; f1_bit = 3; f1_val = 1'b0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("start_clears_fail", 32'(fail1), 0);
      chk("start_bitmask", 32'(bitmask1), 32'hFFFFF);
      repeat (15) tick();
      chk("pre_abort_bist", 32'(bist1), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_bist", 32'(bist1), 0);
      chk("abort_we", 32'(we1), 0);
      chk("abort_re", 32'(re1), 0);
      chk("abort_bitmask", 32'(bitmask1), 0);
      repeat (4) tick();
      chk("abort_done", 32'(done1), 0);
      chk("abort_fail", 32'(fail1), 0);
      f1_en = 1'b0;
      push_trace();
      mon_en = 1'b1;
      run(1'b0, 1'b0, edges, ops);
      mon_en = 1'b0;
      chk("rerun_done_edges", 32'(edges), 42);
      chk("rerun_ops", 32'(ops), 40);
      chk("rerun_trace_left", 32'(sb.size()), 0);
      chk("rerun_fail", 32'(fail1), 0);
      // reset during M3 with a mismatching read in the compare pipe
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int k = 1; k <= 21; k++) begin
         if (k == 20) begin f1_en = 1'b1; f1_addr = 2'd3; f1_bit = 0; f1_val = 1'b1; end
         tick();
      end
      chk("m3_op_we", 32'(we1), 1);
      chk("m3_op_addr", 32'(addr1), 3);
      rst_n = 1'b0;
      tick();
      chk_zero1("midreset");
      rst_n = 1'b1;
      f1_en = 1'b0;
      repeat (3) tick();
      chk("postreset_fail", 32'(fail1), 0);
      chk("postreset_bist", 32'(bist1), 0);
      chk("postreset_done", 32'(done1), 0);
      // start pulses during RUN and DRAIN are ignored
      push_trace();
      mon_en = 1'b1;
      run(1'b0, 1'b1, edges, ops);
      mon_en = 1'b0;
      chk("ignstart_done_edges", 32'(edges), 42);
      chk("ignstart_ops", 32'(ops), 40);
      chk("ignstart_trace_left", 32'(sb.size()), 0);
      chk("ignstart_fail", 32'(fail1), 0);
      // RD_LAT=3, stuck-at-1 bit 0 at addr 0
      f3_en = 1'b1; f3_addr = 2'd0; f3_bit = 0; f3_val = 1'b1;
      run(1'b1, 1'b0, edges, ops);
      chk("lat3_done_edges", 32'(edges), 44);
      chk("lat3_ops", 32'(ops), 40);
      chk("lat3_fail", 32'(fail3), 1);
      chk("lat3_faddr", 32'(faddr3), 0);
      chk("lat3_felem", 32'(felem3), 1);
      repeat (3) tick();
      chk("lat3_done_hold", 32'(done3), 1);
      chk("lat3_felem_hold", 32'(felem3), 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
